// File: rtl/dtw_pkg.sv
// dtw_pkg: shared state type, score constants and cost-to-score mapping
package dtw_pkg;
  localparam int SCORE_MAX = 100;
  localparam int SCORE_W = 32;
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_WAIT, S_REPORT, S_FINISH
  } dtw_seq_state_t;
  function automatic logic [SCORE_W-1:0] cost_to_score(input logic [31:0] cost, input int unsigned shift);
    logic [31:0] c;
    c = cost >> shift;
    return (c >= 32'(SCORE_MAX)) ? '0 : 32'(SCORE_MAX) - c;
  endfunction
endpackage

// File: rtl/dtw_pair_feeder.sv
// dtw_pair_feeder: lock-step pair popping and per-window sample counting
module dtw_pair_feeder #(
  parameter int WINDOW_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  input  logic stop,
  input  logic refer_empty,
  input  logic dance_empty,
  output logic pop,
  output logic window_full,
  output logic stop_flush
);
  localparam int CW = $clog2(WINDOW_LEN + 1);
  logic [CW-1:0] sample_cnt;
  always_comb begin
    pop = active && !stop && !refer_empty && !dance_empty;
    window_full = pop && sample_cnt == CW'(WINDOW_LEN - 1);
    stop_flush = active && stop && sample_cnt != '0;
  end
  always_ff @(posedge clk)
    if (rst || clear) sample_cnt <= '0;
    else if (pop) sample_cnt <= sample_cnt + 1'b1;
endmodule

// File: rtl/dtw_game_sequencer.sv
// dtw_game_sequencer: windows paired samples into the DTW accelerator and scores each window
module dtw_game_sequencer
  import dtw_pkg::*;
#(
  parameter int WINDOW_LEN = 64,
  parameter int NUM_WINDOWS = 16,
  parameter int COST_SHIFT = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               game_stop,
  input  logic               refer_empty,
  input  logic               dance_empty,
  output logic               refer_pop,
  output logic               dance_pop,
  output logic               dtw_valid,
  output logic               dtw_clear,
  output logic               dtw_flush,
  input  logic               dtw_done,
  input  logic [31:0]        dtw_score,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic [SCORE_W-1:0] total_score,
  output logic [15:0]        window_idx,
  output logic               busy,
  output logic               game_done,
  output logic               timeout_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  dtw_seq_state_t state, state_nxt;
  logic [TW-1:0] timer;
  logic stop_pending, stop_eff, pop, window_full, stop_flush, timed_out, win_end, last_win;
  logic [SCORE_W-1:0] new_score;
  logic [SCORE_W:0] sum;
  dtw_pair_feeder #(.WINDOW_LEN(WINDOW_LEN)) u_feeder (
    .clk(clk),
    .rst(rst),
    .active(state == S_FEED),
    .clear(state == S_CLEAR),
    .stop(stop_eff),
    .refer_empty(refer_empty),
    .dance_empty(dance_empty),
    .pop(pop),
    .window_full(window_full),
    .stop_flush(stop_flush)
  );
  always_comb begin
    stop_eff = game_stop || stop_pending;
    timed_out = state == S_WAIT && !dtw_done && timer == TW'(TIMEOUT - 2);
    win_end = state == S_WAIT && (dtw_done || timed_out);
    new_score = cost_to_score(timed_out ? '1 : dtw_score, COST_SHIFT);
    sum = {1'b0, total_score} + {1'b0, new_score};
    last_win = NUM_WINDOWS != 0 && window_idx == 16'(NUM_WINDOWS);
    refer_pop = pop;
    dance_pop = pop;
    dtw_valid = pop;
    dtw_clear = state == S_CLEAR;
    dtw_flush = state == S_FLUSH;
    score_valid = state == S_REPORT;
    busy = state != S_IDLE;
    game_done = state == S_FINISH;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = game_start ? S_CLEAR : S_IDLE;
      S_CLEAR:  state_nxt = S_FEED;
      S_FEED:   state_nxt = stop_eff ? (stop_flush ? S_FLUSH : S_FINISH) : window_full ? S_FLUSH : S_FEED;
      S_FLUSH:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = win_end ? S_REPORT : S_WAIT;
      S_REPORT: state_nxt = (stop_eff || last_win) ? S_FINISH : S_CLEAR;
      default:  state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_nxt;
  always_ff @(posedge clk)
    if (rst) begin
      timer <= '0;
      stop_pending <= 1'b0;
      score <= '0;
      total_score <= '0;
      window_idx <= '0;
      timeout_err <= 1'b0;
    end else begin
      timer <= state == S_WAIT ? timer + 1'b1 : '0;
      stop_pending <= (state == S_IDLE || state == S_FINISH) ? 1'b0 : stop_pending || game_stop;
      if (state == S_IDLE && game_start) begin
        total_score <= '0;
        window_idx <= '0;
        timeout_err <= 1'b0;
      end
      if (win_end) begin
        score <= new_score;
        total_score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        window_idx <= window_idx + 1'b1;
        if (timed_out) timeout_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dtw_game_sequencer.sv
// tb_dtw_game_sequencer: scoreboard bench with a behavioural accelerator and game model
module tb_dtw_game_sequencer;
  import dtw_pkg::*;
  localparam int WL = 4, NW = 2, SH = 8, TO = 16;
  logic clk = 0, rst = 1, game_start = 0, game_stop = 0, refer_empty = 1, dance_empty = 1, dtw_done = 0;
  logic [31:0] dtw_score = 0;
  logic refer_pop, dance_pop, dtw_valid, dtw_clear, dtw_flush, score_valid, busy, game_done, timeout_err;
  logic [31:0] score, total_score;
  logic [15:0] window_idx;
  typedef struct { logic [31:0] score; bit tmo; int lat; int fcyc; } exp_t;
  exp_t sb[$];
  int pairs_q[$];
  logic [31:0] cost_q[$];
  int errors = 0, checks = 0, cyc = 0;
  int pops_in_win = 0, flush_cnt = 0, done_cnt = 0;
  bit rnd = 0, respond = 1, m_tmo = 0;
  logic [31:0] m_total = 0;
  logic [15:0] m_idx = 0;

  dtw_game_sequencer #(.WINDOW_LEN(WL), .NUM_WINDOWS(NW), .COST_SHIFT(SH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_stop(game_stop),
    .refer_empty(refer_empty), .dance_empty(dance_empty),
    .refer_pop(refer_pop), .dance_pop(dance_pop), .dtw_valid(dtw_valid),
    .dtw_clear(dtw_clear), .dtw_flush(dtw_flush), .dtw_done(dtw_done), .dtw_score(dtw_score),
    .score(score), .score_valid(score_valid), .total_score(total_score), .window_idx(window_idx),
    .busy(busy), .game_done(game_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    game_start = 0;
    game_stop = 0;
    if (rnd) begin
      refer_empty = ($urandom_range(0, 3) == 0);
      dance_empty = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic wait_game(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) step();
    check("game_done_seen", 32'(done_cnt), 32'(d0 + 1));
    step();
    check("busy_after_game", {31'd0, busy}, 0);
  endtask

  task automatic full_game(input logic [31:0] c0, input logic [31:0] c1, input int budget);
    int d0, f0;
    d0 = done_cnt;
    f0 = flush_cnt;
    cost_q.push_back(c0);
    cost_q.push_back(c1);
    pairs_q.push_back(WL);
    pairs_q.push_back(WL);
    game_start = 1;
    step();
    wait_game(d0, budget);
    check("flushes_per_game", 32'(flush_cnt), 32'(f0 + NW));
    check("window_idx_end", {16'd0, window_idx}, NW);
    check("total_end", total_score, m_total);
  endtask

  // accelerator: answers each flush three cycles later, or never when respond is clear
  initial begin
    int cnt;
    logic [31:0] c;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      dtw_done = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) dtw_done = 1;
      end
      if (dtw_flush) begin
        c = cost_q.size() > 0 ? cost_q.pop_front() : ($urandom_range(0, 1) ? 32'($urandom_range(0, 32'h6800)) : $urandom);
        if (respond) begin
          dtw_score = c;
          cnt = 3;
          sb.push_back('{cost_to_score(c, SH), 1'b0, 4, cyc});
        end else sb.push_back('{32'd0, 1'b1, TO, cyc});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [32:0] s;
    if (rst) begin
      m_total = 0;
      m_idx = 0;
      m_tmo = 0;
      pops_in_win = 0;
    end else begin
      if (game_start) begin
        m_total = 0;
        m_idx = 0;
        m_tmo = 0;
      end
      if (busy) begin
        checks++;
        if (refer_pop !== dance_pop || refer_pop !== dtw_valid || (refer_pop && (refer_empty || dance_empty))) begin
          errors++;
          $display("FAIL pop_rule: refer_pop=%b dance_pop=%b dtw_valid=%b refer_empty=%b dance_empty=%b", refer_pop, dance_pop, dtw_valid, refer_empty, dance_empty);
        end
      end
      if (dtw_clear) pops_in_win = 0;
      if (refer_pop) pops_in_win++;
      if (dtw_flush) begin
        flush_cnt++;
        if (pairs_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flush: got flush after %0d pairs, required none", pops_in_win);
        end else check("pairs_per_window", 32'(pops_in_win), 32'(pairs_q.pop_front()));
      end
      if (game_done) done_cnt++;
      if (score_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_score: got score %0d, required no score_valid", score);
        end else begin
          e = sb.pop_front();
          s = {1'b0, m_total} + {1'b0, e.score};
          m_total = s[32] ? '1 : s[31:0];
          m_idx++;
          m_tmo = m_tmo | e.tmo;
          check("score", score, e.score);
          check("total_score", total_score, m_total);
          check("window_idx", {16'd0, window_idx}, {16'd0, m_idx});
          check("timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
          check("report_latency", 32'(cyc - e.fcyc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    int d0, f0;
    rst = 1;
    step();
    step();
    rst = 0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_score", score, 0);
    check("rst_total", total_score, 0);
    check("rst_idx", {16'd0, window_idx}, 0);
    check("rst_valid", {31'd0, score_valid | game_done | timeout_err | refer_pop | dtw_clear | dtw_flush}, 0);
    refer_empty = 0;
    dance_empty = 0;
    full_game(32'h1400, 32'h1400, 200);
    check("t1_total_160", total_score, 160);
    check("t1_score_80", score, 80);
    full_game(32'hFFFF_0000, 32'h0, 200);
    check("t2_total_100", total_score, 100);
    full_game(32'h63FF, 32'h6400, 200);
    check("t2_total_1", total_score, 1);
    d0 = done_cnt;
    pairs_q.push_back(WL);
    pairs_q.push_back(WL);
    game_start = 1;
    step();
    for (int i = 0; i < 40 && pops_in_win != 2; i++) step();
    dance_empty = 1;
    repeat (5) step();
    check("gap_no_pops", 32'(pops_in_win), 2);
    dance_empty = 0;
    wait_game(d0, 200);
    check("gap_idx", {16'd0, window_idx}, NW);
    refer_empty = 1;
    dance_empty = 1;
    d0 = done_cnt;
    f0 = flush_cnt;
    pairs_q.push_back(2);
    cost_q.push_back(32'h0A00);
    game_start = 1;
    step();
    step();
    step();
    refer_empty = 0;
    dance_empty = 0;
    step();
    step();
    game_stop = 1;
    step();
    wait_game(d0, 100);
    check("stop_flushes", 32'(flush_cnt), 32'(f0 + 1));
    check("stop_idx", {16'd0, window_idx}, 1);
    check("stop_total", total_score, 90);
    refer_empty = 1;
    dance_empty = 1;
    d0 = done_cnt;
    f0 = flush_cnt;
    game_start = 1;
    step();
    step();
    step();
    game_stop = 1;
    step();
    wait_game(d0, 20);
    check("stop0_no_flush", 32'(flush_cnt), 32'(f0));
    check("stop0_idx", {16'd0, window_idx}, 0);
    refer_empty = 0;
    dance_empty = 0;
    respond = 0;
    full_game(32'h0, 32'h0, 200);
    check("tmo_sticky", {31'd0, timeout_err}, 1);
    check("tmo_score", score, 0);
    respond = 1;
    d0 = done_cnt;
    pairs_q.push_back(WL);
    pairs_q.push_back(WL);
    game_start = 1;
    step();
    check("tmo_cleared", {31'd0, timeout_err}, 0);
    wait_game(d0, 200);
    rnd = 1;
    for (int g = 0; g < 4; g++) full_game($urandom, 32'($urandom_range(0, 32'h7000)), 400);
    rnd = 0;
    refer_empty = 0;
    dance_empty = 0;
    step();
    respond = 0;
    d0 = done_cnt;
    f0 = flush_cnt;
    pairs_q.push_back(WL);
    game_start = 1;
    step();
    for (int i = 0; i < 40 && flush_cnt == f0; i++) step();
    check("rst_test_flush", 32'(flush_cnt), 32'(f0 + 1));
    repeat (3) step();
    rst = 1;
    step();
    rst = 0;
    check("wait_rst_busy", {31'd0, busy}, 0);
    check("wait_rst_total", total_score, 0);
    check("wait_rst_idx", {16'd0, window_idx}, 0);
    check("wait_rst_flags", {31'd0, score_valid | game_done | timeout_err | dtw_flush | refer_pop}, 0);
    repeat (5) step();
    check("wait_rst_no_done", 32'(done_cnt), 32'(d0));
    check("wait_rst_idle", {31'd0, busy}, 0);
    sb.delete();
    pairs_q.delete();
    cost_q.delete();
    respond = 1;
    full_game(32'h3200, 32'h1E00, 200);
    check("clean_total", total_score, 120);
    check("sb_drained", 32'(sb.size() + pairs_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
